// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader slice.
// Holds the loader FSM state encoding (3 bits), the host word width and a
// small helper telling whether a start pulse is honoured in a given state.
package program_loader_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    LOADER_IDLE  = 3'd0,
    LOADER_LEN   = 3'd1,
    LOADER_DATA  = 3'd2,
    LOADER_CSUM  = 3'd3,
    LOADER_DONE  = 3'd4,
    LOADER_ERROR = 3'd5
  } loader_state_e;

  // A new load may only begin once the previous one is finished or never began.
  function automatic logic can_start(input loader_state_e s);
    return (s == LOADER_IDLE) || (s == LOADER_DONE) || (s == LOADER_ERROR);
  endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// Running 32-bit wrapping sum of the payload words of one program image.
// Ports:
//   clk - clock, rst - async active-low reset
//   clr - zero the sum (has priority over en)
//   en  - add d to the sum this cycle
//   d   - word to accumulate, q - current sum
module program_loader_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] sum_q;

  // Accumulator; clear wins so a restart never inherits a stale sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= 32'd0;
    end else if (clr) begin
      sum_q <= 32'd0;
    end else if (en) begin
      sum_q <= sum_q + d;
    end
  end

  assign q = sum_q;

endmodule

// File: rtl/program_loader.sv
// Streams a program image (length, payload words, checksum) from a host
// valid/ready channel into main_memory and keeps the CPU held in reset until
// the whole image has been written and its checksum verified.
// Ports:
//   clk, rst            - clock, async active-low reset
//   start               - one-cycle pulse starting a load (IDLE/DONE/ERROR only)
//   in_valid, in_data   - host word and its valid flag
//   in_ready            - loader accepts in_data on this edge
//   mem_waddr/wdata/wen - main_memory write port, one cycle after each payload accept
//   cpu_hold            - 1 while the CPU must stay in reset
//   done, error         - sticky status of the last load
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned DEPTH     = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [31:0]       mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  loader_state_e     state_q;
  logic [31:0]       remaining_q;
  logic [31:0]       addr_q;
  logic              in_ready_q;
  logic [31:0]       mem_waddr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              mem_wen_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              sum_clr;
  logic              sum_en;
  logic [WORD_W-1:0] sum;

  // A word moves only when the host offers it and our registered ready is up.
  assign accept  = in_valid & in_ready_q;
  // Sum restarts together with the transition into LEN.
  assign sum_clr = start & can_start(state_q);
  assign sum_en  = accept & (state_q == LOADER_DATA);

  program_loader_checksum u_checksum (
    .clk (clk),
    .rst (rst),
    .clr (sum_clr),
    .en  (sum_en),
    .d   (in_data),
    .q   (sum)
  );

  // Loader FSM with all outputs registered. The memory write for a payload
  // word is issued the cycle after it is accepted, so the last write lands
  // in the first CSUM cycle, before any DONE can be reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOADER_IDLE;
      remaining_q <= 32'd0;
      addr_q      <= 32'd0;
      in_ready_q  <= 1'b0;
      mem_waddr_q <= 32'd0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_wen_q <= 1'b0;
      case (state_q)
        LOADER_IDLE, LOADER_DONE, LOADER_ERROR: begin
          if (start) begin
            state_q    <= LOADER_LEN;
            in_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        LOADER_LEN: begin
          if (accept) begin
            if (in_data == 32'd0) begin
              state_q <= LOADER_CSUM;
            end else if (in_data > DEPTH_W) begin
              state_q    <= LOADER_ERROR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q     <= LOADER_DATA;
              remaining_q <= in_data;
              addr_q      <= BASE_ADDR;
            end
          end
        end
        LOADER_DATA: begin
          if (accept) begin
            mem_wen_q   <= 1'b1;
            mem_waddr_q <= addr_q;
            mem_wdata_q <= in_data;
            addr_q      <= addr_q + 32'd1;
            remaining_q <= remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              state_q <= LOADER_CSUM;
            end
          end
        end
        LOADER_CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (in_data == sum) begin
              state_q    <= LOADER_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= LOADER_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= LOADER_IDLE;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
